// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and scheduler state type.
// Used by the dual-issue scheduler and its register-field decoder.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic {
    FIRST  = 1'b0,
    SECOND = 1'b1
  } sched_state_t;

endpackage

// File: rtl/dual_issue_sched_if.sv
// Decode/execute bundle seen by the dual-issue scheduler.
// Counter signals exist only with DUAL_ISSUE_STATS_EN defined.
interface dual_issue_sched_if #(
  parameter int INSTR_W   = 32,
  parameter int REGADDR_W = 5
`ifdef DUAL_ISSUE_STATS_EN
  , parameter int CNT_W   = 32
`endif
);

  logic [INSTR_W-1:0]   instr_d_0;
  logic [INSTR_W-1:0]   instr_d_1;
  logic                 valid_d_0;
  logic                 valid_d_1;
  logic                 flush_d;
  logic                 memtoreg_e_0;
  logic                 memtoreg_e_1;
  logic [REGADDR_W-1:0] writereg_e_0;
  logic [REGADDR_W-1:0] writereg_e_1;
  logic                 issue_0;
  logic                 issue_1;
  logic                 hold_fd;
  logic                 split_q;
`ifdef DUAL_ISSUE_STATS_EN
  logic [CNT_W-1:0]     pair_cnt;
  logic [CNT_W-1:0]     split_cnt;
  logic [CNT_W-1:0]     stall_cnt;
`endif

  modport master (
    output instr_d_0, instr_d_1,
    output valid_d_0, valid_d_1, flush_d,
    output memtoreg_e_0, memtoreg_e_1,
    output writereg_e_0, writereg_e_1,
`ifdef DUAL_ISSUE_STATS_EN
    input  pair_cnt, split_cnt, stall_cnt,
`endif
    input  issue_0, issue_1, hold_fd, split_q
  );

  modport slave (
    input  instr_d_0, instr_d_1,
    input  valid_d_0, valid_d_1, flush_d,
    input  memtoreg_e_0, memtoreg_e_1,
    input  writereg_e_0, writereg_e_1,
`ifdef DUAL_ISSUE_STATS_EN
    output pair_cnt, split_cnt, stall_cnt,
`endif
    output issue_0, issue_1, hold_fd, split_q
  );

endinterface

// File: rtl/instr_reg_decode.sv
// Register-usage decode of one MIPS instruction.
// Sources/destination equal to $0 are reported as unused.
module instr_reg_decode
  import mips_pkg::*;
#(
  parameter int INSTR_W   = 32,
  parameter int REGADDR_W = 5
) (
  input  logic [INSTR_W-1:0]   instr,
  output logic [REGADDR_W-1:0] src_a,
  output logic [REGADDR_W-1:0] src_b,
  output logic [REGADDR_W-1:0] dst,
  output logic                 uses_a,
  output logic                 uses_b,
  output logic                 writes,
  output logic                 is_ctrl
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       ra;
  logic       rb;
  logic       wr;
  logic       is_imm;
  logic       unused_bits;

  assign op = instr[31:26];
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign rd = instr[15:11];
  assign fn = instr[5:0];
  assign unused_bits = ^instr[10:6];
  assign is_imm = (op == OP_ADDI) || (op == OP_ANDI)
               || (op == OP_ORI) || (op == OP_SLTI);

  always_comb begin
    src_a   = REGADDR_W'(rs);
    src_b   = REGADDR_W'(rt);
    dst     = '0;
    ra      = 1'b0;
    rb      = 1'b0;
    wr      = 1'b0;
    is_ctrl = 1'b0;
    unique case (1'b1)
      (op == OP_RTYPE && fn == FN_JR): begin
        ra      = 1'b1;
        is_ctrl = 1'b1;
      end
      (op == OP_RTYPE && fn != FN_JR): begin
        ra  = 1'b1;
        rb  = 1'b1;
        wr  = 1'b1;
        dst = REGADDR_W'(rd);
      end
      (op == OP_LW): begin
        ra  = 1'b1;
        wr  = 1'b1;
        dst = REGADDR_W'(rt);
      end
      (op == OP_SW): begin
        ra = 1'b1;
        rb = 1'b1;
      end
      (op == OP_BEQ || op == OP_BNE): begin
        ra      = 1'b1;
        rb      = 1'b1;
        is_ctrl = 1'b1;
      end
      is_imm: begin
        ra  = 1'b1;
        wr  = 1'b1;
        dst = REGADDR_W'(rt);
      end
      (op == OP_J): is_ctrl = 1'b1;
      (op == OP_JAL): begin
        wr      = 1'b1;
        dst     = REGADDR_W'(5'd31);
        is_ctrl = 1'b1;
      end
      default: ;
    endcase
  end

  assign uses_a = ra && (src_a != '0);
  assign uses_b = rb && (src_b != '0);
  assign writes = wr && (dst != '0);

endmodule

// File: rtl/dual_issue_sched.sv
// Two-lane issue scheduler: pair hazards, load-use stalls, split issue.
// Define DUAL_ISSUE_STATS_EN for pair/split/stall counters.
module dual_issue_sched
  import mips_pkg::*;
#(
  parameter int INSTR_W   = 32,
  parameter int REGADDR_W = 5
`ifdef DUAL_ISSUE_STATS_EN
  , parameter int CNT_W   = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  dual_issue_sched_if.slave bus
);

  sched_state_t state_q;
  sched_state_t state_d;

  logic [REGADDR_W-1:0] a0, b0, d0;
  logic [REGADDR_W-1:0] a1, b1, d1;
  logic ua0, ub0, wr0, ctl0;
  logic ua1, ub1, wr1, ctl1;
  logic lu0, lu1, load_use, split;
  logic issue_0, issue_1, hold_fd;

  instr_reg_decode #(.INSTR_W(INSTR_W), .REGADDR_W(REGADDR_W)) u_dec0 (
    .instr(bus.instr_d_0), .src_a(a0), .src_b(b0), .dst(d0),
    .uses_a(ua0), .uses_b(ub0), .writes(wr0), .is_ctrl(ctl0)
  );

  instr_reg_decode #(.INSTR_W(INSTR_W), .REGADDR_W(REGADDR_W)) u_dec1 (
    .instr(bus.instr_d_1), .src_a(a1), .src_b(b1), .dst(d1),
    .uses_a(ua1), .uses_b(ub1), .writes(wr1), .is_ctrl(ctl1)
  );

  function automatic logic ld_hit(
    input logic                 u,
    input logic [REGADDR_W-1:0] s,
    input logic                 m0,
    input logic [REGADDR_W-1:0] w0,
    input logic                 m1,
    input logic [REGADDR_W-1:0] w1
  );
    return u && ((m0 && s == w0) || (m1 && s == w1));
  endfunction

  always_comb begin
    lu0 = ld_hit(ua0, a0, bus.memtoreg_e_0, bus.writereg_e_0,
                 bus.memtoreg_e_1, bus.writereg_e_1)
       || ld_hit(ub0, b0, bus.memtoreg_e_0, bus.writereg_e_0,
                 bus.memtoreg_e_1, bus.writereg_e_1);
    lu1 = ld_hit(ua1, a1, bus.memtoreg_e_0, bus.writereg_e_0,
                 bus.memtoreg_e_1, bus.writereg_e_1)
       || ld_hit(ub1, b1, bus.memtoreg_e_0, bus.writereg_e_0,
                 bus.memtoreg_e_1, bus.writereg_e_1);
  end

  // In SECOND lane 0 has already left decode, so only lane 1 can stall.
  assign load_use = (bus.valid_d_1 && lu1)
                 || (state_q == FIRST && bus.valid_d_0 && lu0);

  // A branch in lane 0 keeps lane 1 as its delay slot.
  assign split = (wr0 && ((ua1 && a1 == d0) || (ub1 && b1 == d0)))
              || (wr0 && wr1 && d0 == d1)
              || ctl1;

  always_comb begin
    issue_0 = 1'b0;
    issue_1 = 1'b0;
    hold_fd = 1'b0;
    state_d = state_q;
    if (bus.flush_d) begin
      state_d = FIRST;
    end else if (load_use) begin
      hold_fd = 1'b1;
    end else if (state_q == SECOND) begin
      issue_1 = 1'b1;
      state_d = FIRST;
    end else if (bus.valid_d_0 && bus.valid_d_1 && split) begin
      issue_0 = 1'b1;
      hold_fd = 1'b1;
      state_d = SECOND;
    end else begin
      issue_0 = bus.valid_d_0;
      issue_1 = bus.valid_d_1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= FIRST;
    else       state_q <= state_d;
  end

  assign bus.issue_0 = issue_0;
  assign bus.issue_1 = issue_1;
  assign bus.hold_fd = hold_fd;
  assign bus.split_q = (state_q == SECOND);

`ifdef DUAL_ISSUE_STATS_EN
  logic [CNT_W-1:0] pair_cnt, split_cnt, stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      pair_cnt  <= '0;
      split_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (issue_0 && issue_1)
        pair_cnt <= pair_cnt + CNT_W'(1);
      if (state_q == FIRST && state_d == SECOND)
        split_cnt <= split_cnt + CNT_W'(1);
      if (load_use && !bus.flush_d)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign bus.pair_cnt  = pair_cnt;
  assign bus.split_cnt = split_cnt;
  assign bus.stall_cnt = stall_cnt;
`endif

endmodule
